conv1_plane_load_ctrl: RTL

Sequencer that loads a planar CHW image from DDR into the conv1 input stream. It drives one dma_read transfer per channel plane (R, G, then B) and forwards the DMA byte stream to the consumer. Each forwarded byte is tagged with its channel, row and column. It sits between dma_read and the conv1 line-buffer/window logic, and is the only block that starts dma_read on the image-load path.

---
 rtl/conv1_plane_load_ctrl_if.sv | 48 ++++
 rtl/conv1_plane_load_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/conv1_plane_load_ctrl_if.sv
// Signal bundle for the conv1 image-plane loader: host control, dma_read command/stream
// and the tagged pixel stream towards the conv1 line buffer.
interface conv1_plane_load_ctrl_if #(
    parameter int H      = 32,
    parameter int W      = 32,
    parameter int CH     = 3,
    parameter int ADDR_W = 32
);
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;

    logic              start;
    logic [ADDR_W-1:0] img_base;
    logic              busy;
    logic              done;
    logic              err;

    logic              dma_start;
    logic [ADDR_W-1:0] dma_base_addr;
    logic [31:0]       dma_length;
    logic              dma_done;

    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;

    logic              m_valid;
    logic [7:0]        m_data;
    logic [CH_W-1:0]   m_ch;
    logic [ROW_W-1:0]  m_row;
    logic [COL_W-1:0]  m_col;
    logic              m_last;
    logic              m_ready;

    // The loader is the master: it commands dma_read and drives the conv1 stream.
    modport master (
        input  start, img_base, dma_done, s_valid, s_data, m_ready,
        output busy, done, err, dma_start, dma_base_addr, dma_length,
               s_ready, m_valid, m_data, m_ch, m_row, m_col, m_last
    );

    modport slave (
        output start, img_base, dma_done, s_valid, s_data, m_ready,
        input  busy, done, err, dma_start, dma_base_addr, dma_length,
               s_ready, m_valid, m_data, m_ch, m_row, m_col, m_last
    );
endinterface

// File: rtl/conv1_plane_load_ctrl.sv
// Loads a planar CHW image: one dma_read transfer per channel plane, forwarding each byte
// to conv1 tagged with channel/row/column, and flagging short transfers as errors.
module conv1_plane_load_ctrl #(
    parameter int H            = 32,
    parameter int W            = 32,
    parameter int CH           = 3,
    parameter int ADDR_W       = 32,
    parameter int PLANE_STRIDE = H * W
) (
    input  logic clk,
    input  logic rst_n,
    conv1_plane_load_ctrl_if.master bus
);
    localparam int NPIX   = H * W;
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int ROW_W  = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W  = (W > 1) ? $clog2(W) : 1;
    localparam int BEAT_W = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, FINISH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ch;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BEAT_W-1:0] beat_cnt;
    logic              done_seen;
    logic              err_q;
    logic [ADDR_W-1:0] base_q;

    logic in_stream;
    logic plane_full;
    logic last_beat;
    logic stream_valid;
    logic hs;
    logic short_done;
    logic plane_ok;
    logic last_plane;

    assign in_stream    = (state == STREAM);
    assign plane_full   = (beat_cnt == BEAT_W'(NPIX));
    assign last_beat    = (beat_cnt == BEAT_W'(NPIX - 1));
    assign stream_valid = in_stream & bus.s_valid & ~plane_full;
    assign hs           = stream_valid & bus.m_ready;
    assign last_plane   = (ch == CH_W'(CH - 1));

    // A dma_done that coincides with the final handshake completes the plane normally;
    // any other dma_done before the plane is full means dma_read delivered too few bytes.
    assign short_done = in_stream & bus.dma_done & ~plane_full & ~(hs & last_beat);
    assign plane_ok   = in_stream & plane_full & (done_seen | bus.dma_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: every registered signal is updated with non-blocking assignments so all
            // flops see the pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ISSUE;
            ISSUE:   state_nxt = STREAM;
            STREAM: begin
                if (short_done)    state_nxt = FINISH;
                else if (plane_ok) state_nxt = last_plane ? FINISH : ISSUE;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch        <= '0;
            row       <= '0;
            col       <= '0;
            beat_cnt  <= '0;
            done_seen <= 1'b0;
            err_q     <= 1'b0;
            base_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q <= bus.img_base;
                        ch     <= '0;
                        err_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    row       <= '0;
                    col       <= '0;
                    beat_cnt  <= '0;
                    done_seen <= 1'b0;
                end
                STREAM: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (col == COL_W'(W - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    if (bus.dma_done) done_seen <= 1'b1;
                    if (short_done) begin
                        err_q <= 1'b1;
                    end else if (plane_ok && !last_plane) begin
                        ch     <= ch + 1'b1;
                        base_q <= base_q + ADDR_W'(PLANE_STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state == ISSUE) || (state == STREAM);
        bus.done      = (state == FINISH);
        bus.dma_start = (state == ISSUE);
        bus.m_valid   = stream_valid;
        bus.s_ready   = in_stream & bus.m_ready & ~plane_full;
        bus.m_data    = in_stream ? bus.s_data : 8'h00;
        bus.m_last    = last_plane & last_beat & stream_valid;
    end

    assign bus.err           = err_q;
    assign bus.dma_base_addr = base_q;
    assign bus.dma_length    = 32'(NPIX);
    assign bus.m_ch          = ch;
    assign bus.m_row         = row;
    assign bus.m_col         = col;
endmodule
